// File: rtl/phase_accumulator.sv
// DDS phase accumulator: adds tuning word mult to the phase every enabled clock, modulo 2^ACC_W.
// Latency: one clock from mult/en sampled on a rising edge to phase_acc/wrap updating.
// No backpressure: free-running counter; en=0 holds phase_acc and forces wrap low.
module phase_accumulator #(
  parameter int ACC_W  = 4,
  parameter int MULT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MULT_W-1:0] mult,
  output logic [ACC_W-1:0]  phase_acc,
  output logic              wrap
);

  // Tuning word zero-extended to one bit wider than the accumulator so the
  // carry out of the addition lands in the top bit of the sum.
  logic [ACC_W:0] mult_ext;
  logic [ACC_W:0] sum;

  // Widen mult and form the next phase with its carry.
  always_comb begin
    mult_ext = {{(ACC_W + 1 - MULT_W){1'b0}}, mult};
    sum      = {1'b0, phase_acc} + mult_ext;
  end

  // Phase register and period-complete pulse; carry out of the add is the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_acc <= '0;
      wrap      <= 1'b0;
    end else if (en) begin
      phase_acc <= sum[ACC_W-1:0];
      wrap      <= sum[ACC_W];
    end else begin
      wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator with a behavioural modulo-arithmetic model.
// Latency: model and literal checks sampled shortly after each rising edge.
// No backpressure on the DUT; stimulus is a fixed directed sequence.
module tb_phase_accumulator;

  localparam int ACC_W  = 4;
  localparam int MULT_W = 4;
  localparam int MOD    = 1 << ACC_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b1;
  logic [MULT_W-1:0] mult = 4'd2;
  logic [ACC_W-1:0]  phase_acc;
  logic              wrap;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: phase as a plain integer taken modulo 2^ACC_W.
  int m_phase = 0;
  bit m_wrap  = 1'b0;

  phase_accumulator #(.ACC_W(ACC_W), .MULT_W(MULT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mult      (mult),
    .phase_acc (phase_acc),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Model update: integer add, overflow means the sum reached the modulus.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_wrap  <= 1'b0;
    end else if (en) begin
      m_phase <= (m_phase + int'(mult)) % MOD;
      m_wrap  <= (m_phase + int'(mult)) >= MOD;
    end else begin
      m_wrap  <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [ACC_W-1:0] act_p, input int exp_p,
                     input logic act_w, input bit exp_w);
    logic [ACC_W-1:0] ep;
    ep = exp_p[ACC_W-1:0];
    vectors++;
    if (act_p !== ep || act_w !== exp_w) begin
      miscompares++;
      $display("FAIL %s: got phase_acc=%0d wrap=%0b, expected phase_acc=%0d wrap=%0b",
               nm, act_p, act_w, ep, exp_w);
    end
  endtask

  // Compare DUT against the model every cycle, 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    chk("model", phase_acc, m_phase, wrap, m_wrap);
  end

  // Apply inputs away from the edge, clock once, check a hand-computed value.
  task automatic tick(input logic e, input logic [MULT_W-1:0] m, input int exp_p,
                      input bit exp_w, input string nm);
    en   = e;
    mult = m;
    @(posedge clk);
    #2;
    chk(nm, phase_acc, exp_p, wrap, exp_w);
  endtask

  // Assert reset between edges, confirm immediate clear, hold one edge, release.
  task automatic do_reset(input string nm);
    reset = 1'b0;
    #1;
    chk({nm, "_async_clear"}, phase_acc, 0, wrap, 1'b0);
    @(posedge clk);
    #2;
    chk({nm, "_hold"}, phase_acc, 0, wrap, 1'b0);
    reset = 1'b1;
  endtask

  int seq3 [8] = '{3, 6, 9, 12, 15, 2, 5, 8};
  bit wr3  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int seq5 [14] = '{9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11, 0, 5, 10};
  bit wr5  [14] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
  int seqf [4] = '{15, 14, 13, 12};
  bit wrf  [4] = '{0, 1, 1, 1};

  initial begin
    // Reset held low across edges with en=1, mult=2.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      chk("reset_hold", phase_acc, 0, wrap, 1'b0);
    end
    reset = 1'b1;

    // Basic count mult=2: 2,4,...,14,0 with wrap on the return to 0.
    for (int i = 1; i <= 30; i++)
      tick(1'b1, 4'd2, (2 * i) % 16, ((2 * i) % 16) == 0, "count_by_2");

    // Non-divisor increment from 0.
    do_reset("rst_a");
    for (int i = 0; i < 8; i++)
      tick(1'b1, 4'd3, seq3[i], wr3[i], "count_by_3");

    // Enable/hold at 6.
    do_reset("rst_b");
    tick(1'b1, 4'd2, 2, 1'b0, "hold_pre");
    tick(1'b1, 4'd2, 4, 1'b0, "hold_pre");
    tick(1'b1, 4'd2, 6, 1'b0, "hold_pre");
    for (int i = 0; i < 3; i++)
      tick(1'b0, 4'd2, 6, 1'b0, "hold");
    tick(1'b1, 4'd2, 8, 1'b0, "hold_resume");

    // Mid-run mult change 2 -> 5 at phase 4, run to 10, then reset mid-count.
    do_reset("rst_c");
    tick(1'b1, 4'd2, 2, 1'b0, "chg_pre");
    tick(1'b1, 4'd2, 4, 1'b0, "chg_pre");
    for (int i = 0; i < 14; i++)
      tick(1'b1, 4'd5, seq5[i], wr5[i], "chg_by_5");
    do_reset("rst_mid_count");
    tick(1'b1, 4'd5, 5, 1'b0, "restart_by_5");

    // mult=0 stays at 0 with no wrap.
    do_reset("rst_d");
    for (int i = 0; i < 4; i++)
      tick(1'b1, 4'd0, 0, 1'b0, "mult_zero");

    // Max tuning word: decrementing pattern, wrap on every step after the first.
    for (int i = 0; i < 4; i++)
      tick(1'b1, 4'd15, seqf[i], wrf[i], "mult_max");
    // Hold right after a wrapping step drops wrap.
    tick(1'b0, 4'd15, 12, 1'b0, "hold_after_wrap");
    // Sum landing exactly on the modulus: 12 + 4 = 16 -> 0 with wrap.
    tick(1'b1, 4'd4, 0, 1'b1, "exact_modulus");

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_accumulator.md
Name: phase_accumulator

Overview:
- DDS phase accumulator. Adds a frequency tuning word (mult) to an internal phase register every clock and wraps modulo 2^ACC_W.
- The phase_acc output feeds the phase-to-amplitude lookup downstream.
- A one-cycle wrap pulse marks each completed output period. Counter-style block; first stage of the DDS chain.

Parameters:
- ACC_W, 4, width of phase accumulator and phase_acc output (legal 2..32).
- MULT_W, 4, width of tuning word mult (legal 1..ACC_W).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset; 0 clears all state immediately.
- en, input, 1, accumulate enable; 1 = add mult this cycle, 0 = hold.
- mult, input, MULT_W, unsigned frequency tuning word (phase increment per clock), zero-extended to ACC_W.
- phase_acc, output, ACC_W, current phase (registered).
- wrap, output, 1, registered pulse: 1 for the cycle after an addition overflowed past 2^ACC_W-1.

Behaviour:
- One clock domain.
- Reset:
  - reset=0 asynchronously forces phase_acc=0 and wrap=0, independent of clk.
  - Outputs hold those values while reset=0.
  - The first update occurs on the first rising clk edge after reset returns to 1.
- Update on rising clk with reset=1:
  - en=1: sum = phase_acc + zero_ext(mult), computed at ACC_W+1 bits. phase_acc <= sum[ACC_W-1:0]; wrap <= sum[ACC_W].
  - en=0: phase_acc holds; wrap <= 0.
- Latency:
  - mult is sampled each enabled edge, with no input staging.
  - A change in mult affects phase_acc on the next enabled edge.
- Arithmetic: unsigned, modulo 2^ACC_W. No saturation, no signed interpretation.
- Boundary conditions:
  - mult=0: phase_acc constant, wrap stays 0.
  - Sum landing exactly on 2^ACC_W: phase_acc becomes 0 and wrap=1.
  - Sum exceeding 2^ACC_W: phase_acc = remainder and wrap=1.
  - Max mult (2^MULT_W-1 with MULT_W=ACC_W): wraps on nearly every cycle; wrap asserted on each overflow.
  - Reset asserted mid-count: phase_acc=0 immediately, with no partial update.
  - Reset deasserted coincident with a clk edge: that edge performs no update. The count starts on the following edge.
- Output period: for mult a divisor of 2^ACC_W, phase_acc has period 2^ACC_W/mult clocks. Example: ACC_W=4, mult=2 gives an 8-clock period, 0,2,4,…,14,0.
- No X propagation: outputs are defined from reset onward. mult=X while en=1 is illegal.

Test Plan:
- Reset hold: reset=0 for 5 clocks with en=1, mult=2 -> phase_acc=0 and wrap=0 throughout. Also assert reset between edges -> phase_acc clears without waiting for clk.
- Basic count: ACC_W=4, mult=2, en=1, release reset -> phase_acc 2,4,6,…,14,0,2 on successive edges; wrap=1 only in the cycle phase_acc returns to 0; repeats every 8 clocks for 30 clocks.
- Non-divisor increment: mult=3 from 0 -> 3,6,9,12,15,2 (wrap=1),5,… ; wrap=1 exactly on the 15→2 transition.
- Enable/hold: count with mult=2 to 6, en=0 for 3 clocks -> phase_acc stays 6 and wrap=0; en=1 -> 8.
- Mid-run changes: at phase_acc=4 change mult 2→5 -> next value 9, then 14, then 3 (wrap=1). Assert reset at phase_acc=10 -> immediate 0; release -> restart at mult.
- Edge tuning words: mult=0 -> constant 0, no wrap. mult=15 from 0 -> 15,14 (wrap),13 (wrap),… decrementing pattern with wrap on every step after the first.
